// File: rtl/sync_fifo.sv
// ============================================================================
//  Module   : sync_fifo
//  Brief    : Single-clock FIFO with occupancy count, almost-full/empty flags,
//             overflow/underflow pulses. Define SYNC_FIFO_FWFT_EN for
//             first-word-fall-through reads; otherwise reads are registered.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int data_width = 8,
  parameter int fifo_depth = 32,
  parameter int addr_width = $clog2(fifo_depth),
  parameter int af_thresh  = fifo_depth - 2,
  parameter int ae_thresh  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [data_width-1:0] din,
  input  logic                  rd_en,
  output logic [data_width-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [addr_width:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [addr_width:0]   c_depth  = (addr_width+1)'(fifo_depth);
  localparam logic [addr_width:0]   c_af     = (addr_width+1)'(af_thresh);
  localparam logic [addr_width:0]   c_ae     = (addr_width+1)'(ae_thresh);
  localparam logic [addr_width:0]   c_one    = (addr_width+1)'(1);
  localparam logic [addr_width-1:0] c_ptr_one = addr_width'(1);

  logic [data_width-1:0] r_mem [fifo_depth];
  logic [addr_width-1:0] r_wr_ptr;
  logic [addr_width-1:0] r_rd_ptr;
  logic [addr_width:0]   r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  // Flags decode only the count register, never the request inputs.
  assign w_full   = (r_count == c_depth);
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = wr_en & ~w_full;
  assign w_rd_acc = rd_en & ~w_empty;

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= c_af);
  assign almost_empty = (r_count <= c_ae);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= wr_en & w_full;
      r_underflow <= rd_en & w_empty;
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + c_ptr_one;
      unique case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + c_one;
        2'b01:   r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= din;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign dout = r_mem[r_rd_ptr];
`else
  logic [data_width-1:0] r_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= '0;
    end else if (w_rd_acc) begin
      r_dout <= r_mem[r_rd_ptr];
    end
  end

  assign dout = r_dout;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: queue-based reference model plus a
// scoreboard monitor comparing read data and flags on every falling edge.
`default_nettype none

module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] din   = '0;
  logic [DW-1:0] dout;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   count;

  sync_fifo #(
    .data_width(DW),
    .fifo_depth(DEPTH),
    .af_thresh (AF),
    .ae_thresh (AE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .din         (din),
    .rd_en       (rd_en),
    .dout        (dout),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] sb_q[$];
  logic          exp_ovf = 1'b0;
  logic          exp_udf = 1'b0;
  logic          hs      = 1'b0;
  logic [DW-1:0] last_dout = '0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy as a plain queue, rules applied per edge.
  always @(posedge clk or negedge rst_n) begin
    bit f, e;
    if (!rst_n) begin
      model_q.delete();
      sb_q.delete();
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
      hs      = 1'b0;
    end else begin
      f       = (model_q.size() == DEPTH);
      e       = (model_q.size() == 0);
      hs      = rd_en && !empty;
      exp_ovf = wr_en && f;
      exp_udf = rd_en && e;
      if (rd_en && !e) void'(model_q.pop_front());
      if (wr_en && !f) begin
        model_q.push_back(din);
        sb_q.push_back(din);
      end
    end
  end

  // Monitor: compares DUT outputs against the model away from the rising edge.
  always @(negedge clk) begin
    logic [DW-1:0] exp_d;
    if (!rst_n) begin
      last_dout = '0;
    end else begin
      chk("count",        int'(count),        model_q.size());
      chk("full",         int'(full),         int'(model_q.size() == DEPTH));
      chk("empty",        int'(empty),        int'(model_q.size() == 0));
      chk("almost_full",  int'(almost_full),  int'(model_q.size() >= AF));
      chk("almost_empty", int'(almost_empty), int'(model_q.size() <= AE));
      chk("overflow",     int'(overflow),     int'(exp_ovf));
      chk("underflow",    int'(underflow),    int'(exp_udf));
`ifdef SYNC_FIFO_FWFT_EN
      if (hs) begin
        if (sb_q.size() == 0) chk("sb_underrun", 1, 0);
        else void'(sb_q.pop_front());
      end
      if (!empty) begin
        if (sb_q.size() == 0) chk("fwft_sb_empty", 1, 0);
        else chk("fwft_head", int'(dout), int'(sb_q[0]));
      end
`else
      if (hs) begin
        if (sb_q.size() == 0) chk("sb_underrun", 1, 0);
        else begin
          exp_d = sb_q.pop_front();
          chk("rd_data", int'(dout), int'(exp_d));
          last_dout = exp_d;
        end
      end else begin
        chk("dout_hold", int'(dout), int'(last_dout));
      end
`endif
    end
  end

  task automatic drive(input logic w, input logic [DW-1:0] d, input logic r);
    wr_en = w;
    din   = d;
    rd_en = r;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(posedge clk); #1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full",  int'(full), 0);
    chk("rst_ae",    int'(almost_empty), 1);
    chk("rst_af",    int'(almost_full), 0);
    chk("rst_ovf",   int'(overflow), 0);
    chk("rst_udf",   int'(underflow), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst_dout",  int'(dout), 0);
`endif
    @(posedge clk); #2;
    rst_n = 1'b1;

    // 1: fill
    drive(1'b1, 8'hA1, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("t1_fwft_first", int'(dout), 'hA1);
`endif
    drive(1'b1, 8'hA2, 1'b0);
    drive(1'b1, 8'hA3, 1'b0);
    drive(1'b1, 8'hA4, 1'b0);
    chk("t1_count", int'(count), 4);
    chk("t1_full",  int'(full), 1);

    // 2: overflow then drain
    drive(1'b1, 8'hFF, 1'b0);
    chk("t2_overflow", int'(overflow), 1);
    chk("t2_count",    int'(count), 4);
    repeat (4) drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);

    // 3: underflow, then simultaneous on empty
    drive(1'b0, 8'h00, 1'b1);
    chk("t3_underflow", int'(underflow), 1);
    drive(1'b1, 8'h55, 1'b1);
    chk("t3_count", int'(count), 1);
    chk("t3_udf",   int'(underflow), 1);
    drive(1'b0, 8'h00, 1'b1);

    // 4: simultaneous on full, then pointer wrap
    drive(1'b1, 8'hA1, 1'b0);
    drive(1'b1, 8'hA2, 1'b0);
    drive(1'b1, 8'hA3, 1'b0);
    drive(1'b1, 8'hA4, 1'b0);
    drive(1'b1, 8'h77, 1'b1);
    chk("t4_count", int'(count), 3);
    chk("t4_ovf",   int'(overflow), 1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("t4_head",  int'(dout), 'hA2);
`else
    chk("t4_dout",  int'(dout), 'hA1);
`endif
    repeat (3) drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 8'(8'h10 + i), 1'b0);
      drive(1'b0, 8'h00, 1'b1);
    end

    // 5: steady count=2 with simultaneous traffic
    drive(1'b1, 8'h21, 1'b0);
    drive(1'b1, 8'h22, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h30 + i), 1'b1);
    chk("t5_count", int'(count), 2);
    repeat (2) drive(1'b0, 8'h00, 1'b1);

    // 6: asynchronous reset mid-cycle
    drive(1'b1, 8'h01, 1'b0);
    drive(1'b1, 8'h02, 1'b0);
    drive(1'b1, 8'h03, 1'b0);
    wr_en = 1'b0;
    #4;
    rst_n = 1'b0;
    #1;
    chk("t6_count", int'(count), 0);
    chk("t6_empty", int'(empty), 1);
    chk("t6_full",  int'(full), 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(1'b1, 8'h3C, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("t6_dout", int'(dout), 'h3C);
`endif
    drive(1'b0, 8'h00, 1'b0);

    // Randomized traffic with alternating fill/drain bias
    for (int k = 0; k < 600; k++) begin
      int pw;
      pw = ((k / 40) % 2 == 0) ? 75 : 30;
      drive(($urandom_range(0, 99) < pw), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 99) < (100 - pw)));
    end

    repeat (DEPTH + 1) drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
